// File: rtl/lcd_temp_writer_if.sv
//------------------------------------------------------------------------------
// lcd_temp_writer_if
// Sample input and LCD command-port bundle for lcd_temp_writer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lcd_temp_writer_if;
    logic        temp_valid;
    logic [11:0] temp_data;
    logic        rdy;
    logic [7:0]  data;
    logic [1:0]  oper;
    logic        enb;
    logic        busy;
    logic        frame_done;

    modport master (
        input  temp_valid, temp_data, rdy,
        output data, oper, enb, busy, frame_done
    );

    modport slave (
        output temp_valid, temp_data, rdy,
        input  data, oper, enb, busy, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/lcd_temp_writer.sv
//------------------------------------------------------------------------------
// lcd_temp_writer
// Converts a signed 1/16 degC sample to ASCII and streams one 14-byte frame
// to the LCD controller. Optional macro LCD_TEMP_LEADZERO_EN blanks leading zeros.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lcd_temp_writer #(
    parameter logic [7:0] START_ADDR  = 8'h80,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    lcd_temp_writer_if.master bus
);

    localparam int                   c_cnt_w    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 1);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_convert    = 3'd1;
    localparam logic [2:0] c_st_issue      = 3'd2;
    localparam logic [2:0] c_st_wait_busy  = 3'd3;
    localparam logic [2:0] c_st_wait_ready = 3'd4;

    logic [2:0]          r_state;
    logic                r_pend;
    logic [11:0]         r_pend_data;
    logic [11:0]         r_snap;
    logic [3:0]          r_idx;
    logic [3:0]          r_step;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_sign;
    logic [3:0]          r_tenths;
    logic [19:0]         r_dd;

    logic [11:0] w_mag;
    logic [3:0]  w_tenths;
    logic [19:0] w_dd_adj;
    logic        w_last_ack;
    logic        w_take;
    logic        w_active;
    logic        w_h_blank;
    logic        w_t_blank;
    logic [7:0]  w_h_chr;
    logic [7:0]  w_t_chr;
    logic [7:0]  w_byte;

    assign w_mag    = r_snap[11] ? (12'd0 - r_snap) : r_snap;
    assign w_tenths = 4'(({4'd0, w_mag[3:0]} * 8'd10) >> 4);

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        w_dd_adj = r_dd;
        if (r_dd[19:16] >= 4'd5) w_dd_adj[19:16] = r_dd[19:16] + 4'd3;
        if (r_dd[15:12] >= 4'd5) w_dd_adj[15:12] = r_dd[15:12] + 4'd3;
        if (r_dd[11:8]  >= 4'd5) w_dd_adj[11:8]  = r_dd[11:8]  + 4'd3;
    end

    assign w_last_ack = (r_state == c_st_wait_ready) && bus.rdy && (r_idx == 4'd13);
    // A pending sample is consumed either from IDLE or straight out of the last byte.
    assign w_take     = r_pend && ((r_state == c_st_idle) || w_last_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_pend      <= 1'b0;
            r_pend_data <= 12'd0;
            r_snap      <= 12'd0;
            r_idx       <= 4'd0;
            r_step      <= 4'd0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_tenths    <= 4'd0;
            r_dd        <= 20'd0;
        end else begin
            if (bus.temp_valid) begin
                r_pend      <= 1'b1;
                r_pend_data <= bus.temp_data;
            end else if (w_take) begin
                r_pend <= 1'b0;
            end

            if (w_take) begin
                r_snap <= r_pend_data;
                r_step <= 4'd0;
            end

            case (r_state)
                c_st_idle: begin
                    if (r_pend) r_state <= c_st_convert;
                end
                c_st_convert: begin
                    if (r_step == 4'd0) begin
                        r_sign   <= r_snap[11];
                        r_tenths <= w_tenths;
                        r_dd     <= {12'd0, w_mag[11:4]};
                    end else begin
                        r_dd <= w_dd_adj << 1;
                    end
                    if (r_step == 4'd8) begin
                        r_idx   <= 4'd0;
                        r_state <= c_st_issue;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                c_st_issue: begin
                    if (bus.rdy) begin
                        r_cnt   <= '0;
                        r_state <= c_st_wait_busy;
                    end
                end
                c_st_wait_busy: begin
                    if (!bus.rdy)                r_state <= c_st_wait_ready;
                    else if (r_cnt == c_cnt_last) r_state <= c_st_issue;
                    else                          r_cnt   <= r_cnt + 1'b1;
                end
                c_st_wait_ready: begin
                    if (bus.rdy) begin
                        if (r_idx == 4'd13) begin
                            r_state <= r_pend ? c_st_convert : c_st_idle;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= c_st_issue;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef LCD_TEMP_LEADZERO_EN
    assign w_h_blank = (r_dd[19:16] == 4'd0);
    assign w_t_blank = w_h_blank && (r_dd[15:12] == 4'd0);
`else
    assign w_h_blank = 1'b0;
    assign w_t_blank = 1'b0;
`endif

    assign w_h_chr = w_h_blank ? 8'h20 : {4'h3, r_dd[19:16]};
    assign w_t_chr = w_t_blank ? 8'h20 : {4'h3, r_dd[15:12]};

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:    w_byte = START_ADDR;
            4'd1:    w_byte = 8'h54;
            4'd2:    w_byte = 8'h65;
            4'd3:    w_byte = 8'h6D;
            4'd4:    w_byte = 8'h70;
            4'd5:    w_byte = 8'h3A;
            4'd6:    w_byte = r_sign ? 8'h2D : 8'h2B;
            4'd7:    w_byte = w_h_chr;
            4'd8:    w_byte = w_t_chr;
            4'd9:    w_byte = {4'h3, r_dd[11:8]};
            4'd10:   w_byte = 8'h2E;
            4'd11:   w_byte = {4'h3, r_tenths};
            4'd12:   w_byte = 8'hDF;
            4'd13:   w_byte = 8'h43;
            default: w_byte = 8'h00;
        endcase
    end

    assign w_active       = (r_state == c_st_issue) || (r_state == c_st_wait_busy) ||
                            (r_state == c_st_wait_ready);
    assign bus.data       = w_active ? w_byte : 8'h00;
    assign bus.oper       = !w_active ? 2'd0 : ((r_idx == 4'd0) ? 2'd2 : 2'd1);
    assign bus.enb        = (r_state == c_st_issue) && bus.rdy;
    assign bus.busy       = (r_state != c_st_idle);
    assign bus.frame_done = w_last_ack;

endmodule

`default_nettype wire

// File: tb/tb_lcd_temp_writer.sv
//------------------------------------------------------------------------------
// tb_lcd_temp_writer
// Directed bench for lcd_temp_writer with a responsive LCD-controller model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lcd_temp_writer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_temp_writer_if bus();

    lcd_temp_writer #(.START_ADDR(8'h80), .ACK_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Controller model: RDY drops for 'hold' cycles after an accepted ENB.
    int   hold    = 1;
    logic ignore  = 1'b0;
    int   low_cnt = 0;
    int   cyc     = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            bus.rdy <= 1'b1;
            low_cnt <= 0;
        end else if (low_cnt != 0) begin
            low_cnt <= low_cnt - 1;
            if (low_cnt == 1) bus.rdy <= 1'b1;
        end else if (bus.enb && !ignore) begin
            bus.rdy <= 1'b0;
            low_cnt <= hold;
        end
    end

    logic [9:0] q[$];
    int         t[$];
    int         viol_rdy    = 0;
    int         viol_consec = 0;
    int         n_done      = 0;
    bit         prev_enb    = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.enb === 1'b1) begin
                q.push_back({bus.oper, bus.data});
                t.push_back(cyc);
                if (bus.rdy !== 1'b1) viol_rdy++;
                if (prev_enb)         viol_consec++;
            end
            if (bus.frame_done === 1'b1) n_done++;
        end
        prev_enb = (bus.enb === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic string pick(input string plain, input string blanked);
`ifdef LCD_TEMP_LEADZERO_EN
        return blanked;
`else
        return plain;
`endif
    endfunction

    function automatic logic [9:0] exp_byte(input int i, input string body);
        string hdr;
        hdr = "Temp:";
        if (i == 0)       return {2'd2, 8'h80};
        else if (i <= 5)  return {2'd1, hdr[i-1]};
        else if (i <= 11) return {2'd1, body[i-6]};
        else if (i == 12) return {2'd1, 8'hDF};
        else              return {2'd1, 8'h43};
    endfunction

    task automatic check_frame(input string tag, input int base, input string body);
        logic [9:0] obs;
        for (int i = 0; i < 14; i++) begin
            obs = (base + i < q.size()) ? q[base + i] : 10'h3FF;
            check($sformatf("%s[%0d]", tag, i), obs, exp_byte(i, body));
        end
    endtask

    task automatic pulse_sample(input logic [11:0] v);
        @(negedge clk);
        bus.temp_valid = 1'b1;
        bus.temp_data  = v;
        @(negedge clk);
        bus.temp_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) break;
        end
        check(tag, (k < max), 1);
    endtask

    task automatic wait_q(input string tag, input int n, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            @(negedge clk);
            #1;
            if (q.size() >= n) break;
        end
        check(tag, (k < max), 1);
    endtask

    initial begin
        int base;
        int k;
        int first_enb;
        int done_k;

        rst            = 1'b1;
        bus.temp_valid = 1'b0;
        bus.temp_data  = 12'd0;
        repeat (3) @(negedge clk);
        check("rst_data", bus.data, 8'h00);
        check("rst_oper", bus.oper, 2'd0);
        check("rst_enb",  bus.enb,  1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.frame_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Latency and minimum frame time with an ideal controller.
        base = q.size();
        bus.temp_valid = 1'b1;
        bus.temp_data  = 12'h197;
        @(negedge clk);
        bus.temp_valid = 1'b0;
        check("busy_at_N", bus.busy, 1'b0);
        @(negedge clk);
        check("busy_at_N1", bus.busy, 1'b1);
        first_enb = -1;
        done_k    = -1;
        k = 2;
        while (k < 200) begin
            if (bus.enb === 1'b1 && first_enb < 0) first_enb = k;
            if (bus.frame_done === 1'b1) begin
                done_k = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        check("first_enb_cycle", first_enb, 11);
        check("frame_done_cycle", done_k, 52);
        check_frame("pos", base, pick("+025.4", "+ 25.4"));
        @(negedge clk);
        check("busy_after", bus.busy, 1'b0);
        check("done_count1", n_done, 1);

        base = q.size(); pulse_sample(12'h800); wait_done("done_m128", 500);
        check_frame("m128", base, "-128.0");
        base = q.size(); pulse_sample(12'hFFF); wait_done("done_m0", 500);
        check_frame("m0", base, pick("-000.0", "-  0.0"));
        base = q.size(); pulse_sample(12'h000); wait_done("done_p0", 500);
        check_frame("p0", base, pick("+000.0", "+  0.0"));

        // Slow controller.
        hold = 2000;
        base = q.size(); pulse_sample(12'hF38); wait_done("done_slow", 40000);
        check_frame("slow", base, pick("-012.5", "- 12.5"));
        check("slow_enb_count", q.size() - base, 14);
        hold = 1;

        // Ignored strobe on byte 3, then release.
        base = q.size();
        pulse_sample(12'h064);
        wait_q("wait_b2", base + 3, 500);
        @(negedge clk);
        ignore = 1'b1;
        wait_q("wait_retry", base + 6, 500);
        repeat (2) @(negedge clk);
        ignore = 1'b0;
        wait_done("done_retry", 500);
        check("retry_len", q.size() - base, 17);
        check("retry_per1", t[base+4] - t[base+3], 17);
        check("retry_per2", t[base+5] - t[base+4], 17);
        for (int j = 0; j < 17; j++)
            check($sformatf("retry[%0d]", j), q[base+j],
                  exp_byte((j < 3) ? j : ((j < 7) ? 3 : j - 3), pick("+006.2", "+  6.2")));

        // Overlapping samples: last one wins, exactly one extra frame.
        base = q.size();
        pulse_sample(12'h190);
        wait_q("wait_ovl", base + 2, 500);
        pulse_sample(12'h7F0);
        repeat (5) @(negedge clk);
        pulse_sample(12'h800);
        repeat (5) @(negedge clk);
        pulse_sample(12'h0A8);
        wait_done("done_ovl1", 500);
        check_frame("ovl_cur", base, pick("+025.0", "+ 25.0"));
        @(negedge clk);
        check("b2b_busy", bus.busy, 1'b1);
        wait_done("done_ovl2", 500);
        check_frame("ovl_c", base + 14, pick("+010.5", "+ 10.5"));
        repeat (200) @(negedge clk);
        check("ovl_total", q.size() - base, 28);

        // Mid-frame reset, with a pending sample and a strobe coinciding with RST.
        base = q.size();
        pulse_sample(12'h197);
        wait_q("wait_mid", base + 3, 500);
        pulse_sample(12'h123);
        wait_q("wait_b7", base + 8, 500);
        rst            = 1'b1;
        bus.temp_valid = 1'b1;
        bus.temp_data  = 12'h555;
        @(negedge clk);
        check("mrst_data", bus.data, 8'h00);
        check("mrst_oper", bus.oper, 2'd0);
        check("mrst_enb",  bus.enb,  1'b0);
        check("mrst_busy", bus.busy, 1'b0);
        check("mrst_done", bus.frame_done, 1'b0);
        rst            = 1'b0;
        bus.temp_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("mrst_no_enb", q.size() - base, 8);
        check("mrst_idle", bus.busy, 1'b0);

        base = q.size(); pulse_sample(12'h000); wait_done("done_post", 500);
        check_frame("post", base, pick("+000.0", "+  0.0"));

        repeat (5) @(negedge clk);
        check("done_total", n_done, 9);
        check("enb_while_rdy_low", viol_rdy, 0);
        check("enb_consecutive", viol_consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
